mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single 256-bit data memory port between the data cache (master 0) and the instruction cache (master 1).
- Both caches keep their existing line-fill/writeback interface (enable/write/addr/data/ack) unchanged.
- Sits between the cache controllers and the data memory model.
- Grants one whole transaction at a time and forwards ack only to the owner.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 256, cache-line width on all data ports.
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins ties.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-low.
- m0_enable_i  in  1  dcache memory request.
- m0_write_i  in  1  dcache request is a write (writeback).
- m0_addr_i  in  ADDR_WIDTH  dcache line address (low 5 bits zero).
- m0_data_i  in  DATA_WIDTH  dcache writeback line.
- m0_data_o  out  DATA_WIDTH  read line to dcache.
- m0_ack_o  out  1  transaction done, dcache.
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o: same as m0, icache.
- mem_enable_o  out  1  request to data memory.
- mem_write_o  out  1  write strobe to data memory.
- mem_addr_o  out  ADDR_WIDTH  address to data memory.
- mem_data_o  out  DATA_WIDTH  write data to data memory.
- mem_data_i  in  DATA_WIDTH  read data from data memory.
- mem_ack_i  in  1  one-cycle completion pulse from data memory.
- grant_o  out  2  one-hot current owner; 00 = none.

Behaviour:
- States: IDLE, OWN0, OWN1, GAP. State and last-winner flag are registered; all port outputs are combinational from state.
- Reset: rst_i low forces state IDLE and last_winner = 1, so m0 wins the first tie. mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, m0_ack_o, m1_ack_o and grant_o all read 0 while in reset.
- IDLE: mem_enable_o = 0.
  - Only m0_enable_i high -> OWN0.
  - Only m1_enable_i high -> OWN1.
  - Both high: FIXED_PRIO=1 -> OWN0; FIXED_PRIO=0 -> the master that is not last_winner.
  - Neither high -> stay IDLE.
- OWNx:
  - mem_enable_o = mx_enable_i; mem_write_o, mem_addr_o and mem_data_o pass mx_* through.
  - grant_o[x] = 1; the other master sees ack 0 and is stalled by its own controller.
- Completion: mem_ack_i high in OWNx -> mx_ack_o = 1 in the same cycle, last_winner <= x, next state GAP.
- Abort: mx_enable_i low in OWNx without ack -> IDLE, last_winner unchanged. mem_enable_o drops that cycle, which resets the memory's latency counter.
- GAP: exactly one cycle with mem_enable_o = 0 and grant_o = 00, then IDLE.
  - Gives the memory a clean enable edge between transactions.
  - Covers the dcache writeback -> refill sequence, where m0 keeps enable high across the ack.
- Timing:
  - Added latency is 1 cycle from request to mem_enable_o (the IDLE arbitration cycle), plus 2 cycles after each ack (GAP + IDLE) before the next grant.
  - The dcache writeback + refill pair is two separate grants. With FIXED_PRIO=0 the icache may win between them; this is legal because the dcache holds its state and enable.
- m0_data_o and m1_data_o both carry mem_data_i unconditionally; only ack qualifies validity.
- mem_ack_i outside OWNx (spurious) is ignored, with no state change and no ack forwarded.
- Master inputs are not registered; the master must hold addr/data/write stable while its enable is high.

Test Plan:
- Reset: hold rst_i low 3 cycles with both enables high -> grant_o=00 and mem_enable_o=0 throughout; first edge after release -> grant_o=01.
- Single read: m0 enable, addr 0x00000400, memory acks 10 cycles after mem_enable_o rises -> mem_addr_o=0x400, mem_write_o=0, m0_ack_o pulses once with m0_data_o = memory line, m1_ack_o stays 0, grant_o=00 for 2 cycles after ack.
- Contention round-robin (FIXED_PRIO=0): both enables held high continuously, ack latency 10 -> grants alternate 01,10,01,10; each ack goes only to the current owner; exactly 2 idle-enable cycles between transactions.
- Fixed priority (FIXED_PRIO=1): same stimulus -> every grant goes to m0 while m0 keeps requesting; m1 is granted only when m0 drops enable.
- Writeback then refill on m0 while m1 is requesting:
  - Writeback: m0_write_i=1, addr 0x12340000 -> mem_write_o=1 with m0_data_i forwarded.
  - After the ack, m1 is granted next (RR).
  - m0's refill with write=0, addr 0x00000400 is served afterwards with correct mem_addr_o.
- Abort and spurious ack:
  - m1 drops enable 3 cycles into OWN1 -> IDLE next cycle and no ack is forwarded.
  - mem_ack_i pulsed in IDLE -> no m0/m1 ack and state stays IDLE.
  - rst_i asserted mid-OWN0 -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master, one-slave arbiter sharing the 256-bit data memory port between dcache (m0) and icache (m1).
// A grant covers one whole transaction, and the ack goes only to the owner.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_enable_i,
    input  logic                  m0_write_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    input  logic                  m1_enable_i,
    input  logic                  m1_write_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i,
    output logic [1:0]            grant_o
);

    // state | meaning
    // IDLE  | no owner, arbitrate between pending requests
    // OWN0  | dcache owns the memory port
    // OWN1  | icache owns the memory port
    // GAP   | one dead cycle after an ack so memory sees a fresh enable edge
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [1:0] state, state_nxt;
    logic       last_winner, last_winner_nxt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            last_winner <= 1'b1;
        end else begin
            state       <= state_nxt;
            last_winner <= last_winner_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        last_winner_nxt = last_winner;
        case (state)
            IDLE: begin
                if (m0_enable_i && m1_enable_i) begin
                    state_nxt = ((FIXED_PRIO != 0) || last_winner) ? OWN0 : OWN1;
                end else if (m0_enable_i) begin
                    state_nxt = OWN0;
                end else if (m1_enable_i) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                // Completion takes priority over a same-cycle enable drop.
                if (mem_ack_i) begin
                    state_nxt       = GAP;
                    last_winner_nxt = 1'b0;
                end else if (!m0_enable_i) begin
                    state_nxt = IDLE;
                end
            end
            OWN1: begin
                if (mem_ack_i) begin
                    state_nxt       = GAP;
                    last_winner_nxt = 1'b1;
                end else if (!m1_enable_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        grant_o      = 2'b00;
        case (state)
            OWN0: begin
                mem_enable_o = m0_enable_i;
                mem_write_o  = m0_write_i;
                mem_addr_o   = m0_addr_i;
                mem_data_o   = m0_data_i;
                m0_ack_o     = mem_ack_i;
                grant_o      = 2'b01;
            end
            OWN1: begin
                mem_enable_o = m1_enable_i;
                mem_write_o  = m1_write_i;
                mem_addr_o   = m1_addr_i;
                mem_data_o   = m1_data_i;
                m1_ack_o     = mem_ack_i;
                grant_o      = 2'b10;
            end
            default: ;
        endcase
    end

    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance (a_*) and fixed-priority instance (b_*)
// share master inputs; each has its own latency-10 memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int LAT = 10;
    localparam logic [255:0] LINE_R = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] LINE_W = {8{32'hA5A5_0F0F}};

    logic         clk = 1'b0;
    logic         rst;
    logic         m0_en, m0_wr, m1_en, m1_wr;
    logic [31:0]  m0_addr, m1_addr;
    logic [255:0] m0_wdata, m1_wdata, mem_rdata;
    logic         auto_a, man_ack_a, model_ack_a, model_ack_b, mem_ack_a;
    int           cnt_a, cnt_b;

    logic [255:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, b_m0_rdata, b_m1_rdata, b_mem_wdata;
    logic         a_m0_ack, a_m1_ack, a_mem_en, a_mem_wr, b_m0_ack, b_m1_ack, b_mem_en, b_mem_wr;
    logic [31:0]  a_mem_addr, b_mem_addr;
    logic [1:0]   a_grant, b_grant;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mem_ack_a = auto_a ? model_ack_a : man_ack_a;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(256), .FIXED_PRIO(0)) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .m0_enable_i(m0_en), .m0_write_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m0_data_o(a_m0_rdata), .m0_ack_o(a_m0_ack),
        .m1_enable_i(m1_en), .m1_write_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m1_data_o(a_m1_rdata), .m1_ack_o(a_m1_ack),
        .mem_enable_o(a_mem_en), .mem_write_o(a_mem_wr), .mem_addr_o(a_mem_addr),
        .mem_data_o(a_mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack_a),
        .grant_o(a_grant)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(256), .FIXED_PRIO(1)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .m0_enable_i(m0_en), .m0_write_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m0_data_o(b_m0_rdata), .m0_ack_o(b_m0_ack),
        .m1_enable_i(m1_en), .m1_write_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m1_data_o(b_m1_rdata), .m1_ack_o(b_m1_ack),
        .mem_enable_o(b_mem_en), .mem_write_o(b_mem_wr), .mem_addr_o(b_mem_addr),
        .mem_data_o(b_mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(model_ack_b),
        .grant_o(b_grant)
    );

    // Memory models: ack during the LAT-th consecutive cycle of enable; updated 2ns after the edge.
    always @(posedge clk) begin
        #2;
        if (a_mem_en) begin
            cnt_a++;
            model_ack_a = (cnt_a == LAT);
        end else begin
            cnt_a = 0;
            model_ack_a = 1'b0;
        end
        if (b_mem_en) begin
            cnt_b++;
            model_ack_b = (cnt_b == LAT);
        end else begin
            cnt_b = 0;
            model_ack_b = 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        m0_en = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_en = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
        man_ack_a = 1'b0; auto_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_en = 1'b1; m1_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (a_grant !== 2'b00 || a_mem_en !== 1'b0 || b_grant !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: grant %b/%b mem_en %b, want 00/00 0", i, a_grant, b_grant, a_mem_en);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (a_grant !== 2'b01 || b_grant !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b/%b want 01/01", a_grant, b_grant);
        end
    endtask

    task automatic test_single_read();
        int en_cycles = 0;
        int acks = 0;
        bit done = 0;
        do_reset();
        mem_rdata = LINE_R;
        m0_addr = 32'h0000_0400; m0_en = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            n_chk++;
            if (a_m1_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL single_m1_ack: got %b want 0", a_m1_ack);
            end
            if (a_mem_en) begin
                en_cycles++;
                n_chk++;
                if (a_mem_addr !== 32'h400 || a_mem_wr !== 1'b0 || a_grant !== 2'b01) begin
                    n_fail++;
                    $display("FAIL single_req: addr %h wr %b grant %b want 400 0 01", a_mem_addr, a_mem_wr, a_grant);
                end
            end
            if (a_m0_ack) begin
                acks++;
                done = 1;
                m0_en = 1'b0;
                n_chk++;
                if (a_m0_rdata !== LINE_R || en_cycles !== LAT) begin
                    n_fail++;
                    $display("FAIL single_ack: data %h en_cycles %0d want %h %0d", a_m0_rdata, en_cycles, LINE_R, LAT);
                end
            end
        end
        n_chk++;
        if (acks !== 1) begin
            n_fail++;
            $display("FAIL single_ack_count: got %0d want 1", acks);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if (a_grant !== 2'b00 || a_mem_en !== 1'b0 || a_m0_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL single_gap %0d: grant %b mem_en %b ack %b want 00 0 0", i, a_grant, a_mem_en, a_m0_ack);
            end
        end
    endtask

    task automatic test_contention_rr();
        logic [1:0] seq[$];
        logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0] prev = 2'b00;
        logic [31:0] exp_addr;
        int idle = 0;
        do_reset();
        m0_addr = 32'h100; m1_addr = 32'h200; m0_en = 1'b1; m1_en = 1'b1;
        for (int i = 0; i < 300 && seq.size() < 5; i++) begin
            @(negedge clk);
            if (a_grant != 2'b00 && a_grant != prev) begin
                if (seq.size() > 0) begin
                    n_chk++;
                    if (idle !== 2) begin
                        n_fail++;
                        $display("FAIL rr_gap: got %0d idle cycles want 2", idle);
                    end
                end
                exp_addr = (a_grant == 2'b01) ? 32'h100 : 32'h200;
                n_chk++;
                if (a_mem_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL rr_addr: got %h want %h", a_mem_addr, exp_addr);
                end
                seq.push_back(a_grant);
                idle = 0;
            end
            if (!a_mem_en) idle++;
            n_chk++;
            if ((a_m0_ack && a_grant !== 2'b01) || (a_m1_ack && a_grant !== 2'b10)) begin
                n_fail++;
                $display("FAIL rr_ack_route: ack %b%b grant %b", a_m1_ack, a_m0_ack, a_grant);
            end
            prev = a_grant;
        end
        n_chk++;
        if (seq.size() < 5) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d grants want 5", seq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (seq[k] !== exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %b want %b", k, seq[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_fixed_prio();
        logic [1:0] seq[$];
        logic [1:0] exp_seq [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        logic [1:0] prev = 2'b00;
        int idle = 0;
        do_reset();
        m0_addr = 32'h100; m1_addr = 32'h200; m0_en = 1'b1; m1_en = 1'b1;
        for (int i = 0; i < 300 && seq.size() < 4; i++) begin
            @(negedge clk);
            if (b_grant != 2'b00 && b_grant != prev) begin
                if (seq.size() > 0) begin
                    n_chk++;
                    if (idle !== 2) begin
                        n_fail++;
                        $display("FAIL fp_gap: got %0d idle cycles want 2", idle);
                    end
                end
                seq.push_back(b_grant);
                idle = 0;
            end
            if (!b_mem_en) idle++;
            n_chk++;
            if ((b_m0_ack && b_grant !== 2'b01) || (b_m1_ack && b_grant !== 2'b10)) begin
                n_fail++;
                $display("FAIL fp_ack_route: ack %b%b grant %b", b_m1_ack, b_m0_ack, b_grant);
            end
            if (b_m0_ack && seq.size() == 3) m0_en = 1'b0;
            prev = b_grant;
        end
        n_chk++;
        if (seq.size() < 4) begin
            n_fail++;
            $display("FAIL fp_timeout: got %0d grants want 4", seq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (seq[k] !== exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL fp_order[%0d]: got %b want %b", k, seq[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_wb_refill();
        logic [1:0] seq[$];
        logic [1:0] exp_seq [3] = '{2'b01, 2'b10, 2'b01};
        logic [1:0] prev = 2'b00;
        bit done = 0;
        do_reset();
        m0_en = 1'b1; m0_wr = 1'b1; m0_addr = 32'h1234_0000; m0_wdata = LINE_W;
        m1_en = 1'b1; m1_wr = 1'b0; m1_addr = 32'h2000;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (a_grant != 2'b00 && a_grant != prev) seq.push_back(a_grant);
            if (a_grant == 2'b01 && seq.size() == 1) begin
                n_chk++;
                if (a_mem_wr !== 1'b1 || a_mem_wdata !== LINE_W || a_mem_addr !== 32'h1234_0000) begin
                    n_fail++;
                    $display("FAIL wb_fwd: wr %b addr %h data %h", a_mem_wr, a_mem_addr, a_mem_wdata);
                end
            end
            if (a_grant == 2'b10) begin
                n_chk++;
                if (a_mem_wr !== 1'b0 || a_mem_addr !== 32'h2000) begin
                    n_fail++;
                    $display("FAIL wb_m1_fwd: wr %b addr %h want 0 00002000", a_mem_wr, a_mem_addr);
                end
            end
            if (a_grant == 2'b01 && seq.size() == 3) begin
                n_chk++;
                if (a_mem_wr !== 1'b0 || a_mem_addr !== 32'h400) begin
                    n_fail++;
                    $display("FAIL refill_fwd: wr %b addr %h want 0 00000400", a_mem_wr, a_mem_addr);
                end
            end
            if (a_m0_ack && seq.size() == 1) begin
                m0_wr = 1'b0; m0_addr = 32'h400; m0_wdata = '0;
            end
            if (a_m1_ack) m1_en = 1'b0;
            if (a_m0_ack && seq.size() == 3) begin
                m0_en = 1'b0;
                done = 1;
            end
            prev = a_grant;
        end
        n_chk++;
        if (!done || seq.size() != 3) begin
            n_fail++;
            $display("FAIL wb_timeout: done %0d grants %0d want 1 3", done, seq.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (seq[k] !== exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL wb_order[%0d]: got %b want %b", k, seq[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_abort_spurious();
        do_reset();
        auto_a = 1'b0;
        m1_en = 1'b1;
        @(negedge clk);
        n_chk++;
        if (a_grant !== 2'b10 || a_mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_grant: grant %b mem_en %b want 10 1", a_grant, a_mem_en);
        end
        repeat (2) @(negedge clk);
        m1_en = 1'b0;
        #1;
        n_chk++;
        if (a_mem_en !== 1'b0 || a_m1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_drop: mem_en %b ack %b want 0 0", a_mem_en, a_m1_ack);
        end
        @(negedge clk);
        n_chk++;
        if (a_grant !== 2'b00 || a_m1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: grant %b ack %b want 00 0", a_grant, a_m1_ack);
        end
        man_ack_a = 1'b1;
        #1;
        n_chk++;
        if (a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_ack: acks %b%b want 00", a_m1_ack, a_m0_ack);
        end
        @(negedge clk);
        n_chk++;
        if (a_grant !== 2'b00 || a_mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_state: grant %b mem_en %b want 00 0", a_grant, a_mem_en);
        end
        man_ack_a = 1'b0;
        m0_en = 1'b1;
        @(negedge clk);
        n_chk++;
        if (a_grant !== 2'b01) begin
            n_fail++;
            $display("FAIL spurious_still_idle: grant %b want 01", a_grant);
        end
        m0_wr = 1'b1; m0_addr = 32'h1234_0000; m0_wdata = LINE_W;
        man_ack_a = 1'b1;
        rst = 1'b0;
        #1;
        n_chk++;
        if (a_grant !== 2'b00 || a_mem_en !== 1'b0 || a_mem_wr !== 1'b0 || a_mem_addr !== 32'h0 ||
            a_mem_wdata !== 256'h0 || a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: grant %b en %b wr %b addr %h ack %b%b want all 0",
                     a_grant, a_mem_en, a_mem_wr, a_mem_addr, a_m1_ack, a_m0_ack);
        end
        @(negedge clk);
        man_ack_a = 1'b0;
        m0_en = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        m0_en = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_en = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
        mem_rdata = '0; man_ack_a = 1'b0; auto_a = 1'b1;
        model_ack_a = 1'b0; model_ack_b = 1'b0; cnt_a = 0; cnt_b = 0;
        test_reset();
        test_single_read();
        test_contention_rr();
        test_fixed_prio();
        test_wb_refill();
        test_abort_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
